// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: multi-sector SD read engine. Pulls bytes from sd_spi one handshake
// at a time, packs them little-endian into WORD_BYTES-wide words and buffers the words in
// a first-word-fall-through FIFO behind a valid/ready stream.
module sd_sector_streamer #(
    parameter int unsigned WORD_BYTES   = 1,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned COUNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             start_addr,
    input  logic [COUNT_W-1:0]      sector_count,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2:0]              error_code,
    output logic                    sd_rd,
    output logic [31:0]             sd_addr,
    input  logic [7:0]              sd_dout,
    input  logic                    sd_dout_avail,
    output logic                    sd_dout_taken,
    input  logic                    sd_busy,
    input  logic                    sd_error,
    input  logic [2:0]              sd_error_code,
    output logic                    m_valid,
    output logic [8*WORD_BYTES-1:0] m_data,
    output logic                    m_last,
    output logic                    m_end,
    input  logic                    m_ready
);

    localparam int unsigned WORD_W  = 8 * WORD_BYTES;
    localparam int unsigned IDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned BYTE_W  = $clog2(SECTOR_BYTES);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = WORD_W + 2;

    typedef enum logic [2:0] {
        StIdle, StReq, StXfer, StTake, StSectEnd, StDone, StErr
    } state_t;

    state_t               state_q;
    logic [COUNT_W-1:0]   remaining_q;
    logic [BYTE_W-1:0]    byte_cnt_q;
    logic [IDX_W-1:0]     pack_idx_q;
    logic [WORD_W-1:0]    pack_buf_q;

    logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     fifo_cnt_q;
    logic [ENTRY_W-1:0]   head;

    logic                 word_complete;
    logic                 fifo_room;
    logic                 pop;
    logic                 accept;
    logic                 push;
    logic                 push_last;
    logic                 push_end;
    logic                 active;
    logic [WORD_W-1:0]    push_word;

    assign active        = (state_q != StIdle) && (state_q != StErr);
    // Taken must coincide with the capture cycle, so it is decoded rather than registered.
    assign sd_dout_taken = accept;

    assign head    = fifo_mem_q[rd_ptr_q];
    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = m_valid ? head[WORD_W-1:0] : '0;
    assign m_last  = m_valid & head[WORD_W];
    assign m_end   = m_valid & head[WORD_W+1];

    // Byte acceptance: a byte that completes a word needs FIFO room (a same-cycle pop counts).
    always_comb begin
        word_complete = (pack_idx_q == IDX_W'(WORD_BYTES - 1));
        pop           = m_valid & m_ready;
        fifo_room     = (fifo_cnt_q != CNT_W'(FIFO_DEPTH)) | pop;
        accept        = !reset && (state_q == StXfer) && sd_dout_avail && !sd_error &&
                        (!word_complete || fifo_room);
        push          = accept && word_complete;
        push_last     = (byte_cnt_q == BYTE_W'(SECTOR_BYTES - 1));
        push_end      = push_last && (remaining_q == COUNT_W'(1));
        push_word     = pack_buf_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (pack_idx_q == IDX_W'(k)) begin
                push_word[8*k +: 8] = sd_dout;
            end
        end
    end

    // Sector/byte sequencing FSM with registered control outputs and packer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= 3'd0;
            sd_rd       <= 1'b0;
            sd_addr     <= 32'd0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            pack_idx_q  <= '0;
            pack_buf_q  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                pack_buf_q <= push_word;
                pack_idx_q <= word_complete ? '0 : pack_idx_q + 1'b1;
                byte_cnt_q <= push_last ? '0 : byte_cnt_q + 1'b1;
            end
            if (active && sd_error) begin
                state_q    <= StErr;
                error      <= 1'b1;
                error_code <= sd_error_code;
                sd_rd      <= 1'b0;
                pack_idx_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            error <= 1'b0;
                            if (sector_count != '0) begin
                                sd_addr     <= start_addr;
                                remaining_q <= sector_count;
                                byte_cnt_q  <= '0;
                                pack_idx_q  <= '0;
                                sd_rd       <= 1'b1;
                                busy        <= 1'b1;
                                state_q     <= StReq;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    StReq: begin
                        if (sd_busy) begin
                            sd_rd   <= 1'b0;
                            state_q <= StXfer;
                        end
                    end
                    StXfer: begin
                        if (accept) begin
                            state_q <= StTake;
                        end
                    end
                    StTake: begin
                        // Counter returns to 0 only after the last byte of the sector.
                        if (!sd_dout_avail) begin
                            state_q <= (byte_cnt_q == '0) ? StSectEnd : StXfer;
                        end
                    end
                    StSectEnd: begin
                        if (!sd_busy) begin
                            sd_addr     <= sd_addr + 32'd1;
                            remaining_q <= remaining_q - 1'b1;
                            if (remaining_q == COUNT_W'(1)) begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                byte_cnt_q <= '0;
                                sd_rd      <= 1'b1;
                                state_q    <= StReq;
                            end
                        end
                    end
                    StDone: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    StErr: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    // FIFO storage: {end, last, data} per entry.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {push_end, push_last, push_word};
        end
    end

endmodule
